cdb_arbiter: RTL

//  Shares the single common data bus (CDB) between the functional units (alu, brAlu, mul, div, mem).

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Common data bus arbitration bundle: per-FU result requests in, registered CDB broadcast out.
// slave is the arbiter side, master is the functional-unit / ROB side.
interface cdb_arbiter_if #(
  parameter int NUM_FU   = 5,
  parameter int ROB_IX_W = 3,
  parameter int DATA_W   = 32
);
  logic [NUM_FU-1:0]          fu_valid_in;
  logic [NUM_FU*ROB_IX_W-1:0] fu_rob_ix_in;
  logic [NUM_FU*DATA_W-1:0]   fu_data_in;
  logic [ROB_IX_W-1:0]        head_rob_ix_in;
  logic                       flush_in;
  logic [NUM_FU-1:0]          fu_read_out;
  logic                       cdb_valid_out;
  logic [ROB_IX_W-1:0]        cdb_rob_ix_out;
  logic [DATA_W-1:0]          cdb_value_out;
  logic [31:0]                cdb_dest_out;
  logic [15:0]                conflict_cnt_out;

  modport slave (
    input  fu_valid_in, fu_rob_ix_in, fu_data_in, head_rob_ix_in, flush_in,
    output fu_read_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_dest_out,
           conflict_cnt_out
  );

  modport master (
    output fu_valid_in, fu_rob_ix_in, fu_data_in, head_rob_ix_in, flush_in,
    input  fu_read_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_dest_out,
           conflict_cnt_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one completed FU result per cycle onto the registered common data bus.
// The FU holding the ROB-head result wins; otherwise round-robin from rr_ptr.
module cdb_arbiter #(
  parameter int NUM_FU   = 5,
  parameter int ROB_IX_W = 3,
  parameter int DATA_W   = 32
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  cdb_arbiter_if.slave   bus
);
  localparam int IX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SW   = IX_W + 1;

  logic [NUM_FU-1:0]   read_q;
  logic [NUM_FU-1:0]   elig;
  logic [ROB_IX_W-1:0] rob_ix_a [NUM_FU];
  logic [DATA_W-1:0]   data_a   [NUM_FU];
  logic [IX_W-1:0]     rr_ptr;
  logic [IX_W-1:0]     grant_ix;
  logic [IX_W-1:0]     scan_ix;
  logic [IX_W-1:0]     rr_next;
  logic [SW-1:0]       scan_sum;
  logic [SW-1:0]       pop_cnt;
  logic                head_hit;
  logic                grant_vld;
  logic                conflict;
  logic                cdb_valid_q;
  logic [ROB_IX_W-1:0] cdb_rob_ix_q;
  logic [DATA_W-1:0]   cdb_value_q;
  logic [15:0]         conflict_cnt_q;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      rob_ix_a[i] = bus.fu_rob_ix_in[i*ROB_IX_W +: ROB_IX_W];
      data_a[i]   = bus.fu_data_in[i*DATA_W +: DATA_W];
    end
  end

  // The FU pulsed last cycle still shows valid while it consumes its read pulse.
  assign elig = bus.fu_valid_in & ~read_q;

  // Both scans run from the high end so the lowest index / nearest rr slot is written last.
  always_comb begin
    head_hit = 1'b0;
    grant_ix = '0;
    scan_sum = '0;
    scan_ix  = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (elig[i] && (rob_ix_a[i] == bus.head_rob_ix_in)) begin
        head_hit = 1'b1;
        grant_ix = IX_W'(i);
      end
    end
    if (!head_hit) begin
      for (int k = NUM_FU - 1; k >= 0; k--) begin
        scan_sum = SW'(rr_ptr) + SW'(k);
        if (scan_sum >= SW'(NUM_FU)) scan_sum = scan_sum - SW'(NUM_FU);
        scan_ix = scan_sum[IX_W-1:0];
        if (elig[scan_ix]) grant_ix = scan_ix;
      end
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_FU; i++) pop_cnt = pop_cnt + SW'(elig[i]);
  end

  assign grant_vld = |elig;
  assign conflict  = (pop_cnt >= SW'(2));
  assign rr_next   = (grant_ix == IX_W'(NUM_FU - 1)) ? '0 : grant_ix + IX_W'(1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      read_q         <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_rob_ix_q   <= '0;
      cdb_value_q    <= '0;
      rr_ptr         <= '0;
      conflict_cnt_q <= '0;
    end else begin
      read_q      <= grant_vld ? (NUM_FU'(1) << grant_ix) : '0;
      cdb_valid_q <= grant_vld & ~bus.flush_in;
      if (grant_vld) begin
        cdb_rob_ix_q <= rob_ix_a[grant_ix];
        cdb_value_q  <= data_a[grant_ix];
        rr_ptr       <= rr_next;
      end
      if (conflict && (conflict_cnt_q != 16'hFFFF)) conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign bus.fu_read_out      = read_q;
  assign bus.cdb_valid_out    = cdb_valid_q;
  assign bus.cdb_rob_ix_out   = cdb_rob_ix_q;
  assign bus.cdb_value_out    = cdb_value_q;
  assign bus.cdb_dest_out     = 32'd0;
  assign bus.conflict_cnt_out = conflict_cnt_q;
endmodule
